// File: rtl/lsu_data_memory.sv
// lsu_data_memory: byte-addressed little-endian data memory for the load/store
// path. It uses a valid/ready request and response handshake and a fixed
// number of wait states. Misaligned, out-of-range and illegal-size accesses
// are reported through resp_err and never modify memory.
module lsu_data_memory #(
  parameter int XLEN        = 32,
  parameter int DEPTH_BYTES = 4096,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [31:0]     req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            busy
);

  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [31:0]     addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;
  logic            valid_q;
  logic            ready_q;
  logic            busy_q;

  logic [7:0]      mem [DEPTH_BYTES];

  logic [AW-1:0]   idx0, idx1, idx2, idx3;
  logic [7:0]      byte0, byte1, byte2, byte3;
  logic            err_d;
  logic [XLEN-1:0] rdata_d;
  logic            enter_resp;
  logic            commit;

  // Any illegal size, misalignment or address bit beyond the array is an error.
  // Upper address bits are checked, never wrapped.
  function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr);
    logic e;
    e = 1'b0;
    if (size == 2'b11) e = 1'b1;
    if ((size == 2'b01) && addr[0]) e = 1'b1;
    if ((size == 2'b10) && (addr[1:0] != 2'b00)) e = 1'b1;
    if ((addr >> AW) != 32'd0) e = 1'b1;
    return e;
  endfunction

  // Assemble load data from little-endian bytes. Sub-word loads are
  // sign- or zero-extended.
  function automatic logic [XLEN-1:0] load_extend(input logic [1:0] size, input logic uns,
                                                  input logic [7:0] b0, input logic [7:0] b1,
                                                  input logic [7:0] b2, input logic [7:0] b3);
    logic [XLEN-1:0] r;
    case (size)
      2'b00:   r = uns ? {{(XLEN-8){1'b0}}, b0} : {{(XLEN-8){b0[7]}}, b0};
      2'b01:   r = uns ? {{(XLEN-16){1'b0}}, b1, b0} : {{(XLEN-16){b1[7]}}, b1, b0};
      default: r = {b3, b2, b1, b0};
    endcase
    return r;
  endfunction

  // Byte lanes of the captured access. Wraparound inside the index only
  // matters for accesses already flagged as errors.
  assign idx0  = addr_q[AW-1:0];
  assign idx1  = idx0 + AW'(1);
  assign idx2  = idx0 + AW'(2);
  assign idx3  = idx0 + AW'(3);
  assign byte0 = mem[idx0];
  assign byte1 = mem[idx1];
  assign byte2 = mem[idx2];
  assign byte3 = mem[idx3];

  assign err_d      = access_err(size_q, addr_q);
  assign rdata_d    = (err_d || we_q) ? '0 : load_extend(size_q, uns_q, byte0, byte1, byte2, byte3);
  assign enter_resp = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign commit     = enter_resp && we_q && !err_d;

  // Request/response FSM. Latency is one capture cycle plus WAIT_STATES
  // cycles. The response is registered and held until it is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= 4'(WAIT_STATES);
            state_q <= S_WAIT;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_RESP;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Store commit on the edge that enters RESP. The array is not reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[idx0] <= wdata_q[7:0];
      if (size_q != 2'b00) begin
        mem[idx1] <= wdata_q[15:8];
      end
      if (size_q == 2'b10) begin
        mem[idx2] <= wdata_q[23:16];
        mem[idx3] <= wdata_q[31:24];
      end
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_lsu_data_memory.sv
// Directed testbench for lsu_data_memory with WAIT_STATES=2 and DEPTH_BYTES=4096.
module tb_lsu_data_memory;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int total  = 0;
  int passed = 0;

  lsu_data_memory #(.XLEN(32), .DEPTH_BYTES(4096), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a request and step past its accept edge. Called #1 after an edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Wait, with a bound, for resp_valid. Then capture the response and
  // complete the handshake. lat is the number of edges after accept.
  task automatic wait_resp(output int lat, output logic [31:0] data, output logic err);
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    data = resp_rdata;
    err  = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] data, output logic err);
    issue(we, size, uns, addr, wdata);
    wait_resp(lat, data, err);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    total++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0 ||
        busy !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL reset_outputs: got valid=%b rdata=%h err=%b busy=%b ready=%b, want 0 0 0 0 1",
               resp_valid, resp_rdata, resp_err, busy, req_ready);
    end else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL after_reset_idle: got ready=%b busy=%b, want 1 0", req_ready, busy);
    end else passed++;
  endtask

  task automatic test_word;
    int lat; logic [31:0] d; logic e;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, d, e);
    total++;
    if (lat !== 3 || e !== 1'b0 || d !== 32'd0) begin
      $display("FAIL sw_0x10: got lat=%0d err=%b rdata=%h, want 3 0 00000000", lat, e, d);
    end else passed++;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, d, e);
    total++;
    if (lat !== 3 || e !== 1'b0 || d !== 32'hDEADBEEF) begin
      $display("FAIL lw_0x10: got lat=%0d err=%b rdata=%h, want 3 0 deadbeef", lat, e, d);
    end else passed++;
  endtask

  task automatic test_subword;
    int lat; logic [31:0] d; logic e;
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, d, e);
    total++;
    if (d !== 32'hFFFFFFDE || e !== 1'b0) begin
      $display("FAIL lb_0x13: got %h err=%b, want ffffffde 0", d, e);
    end else passed++;
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, d, e);
    total++;
    if (d !== 32'h000000DE || e !== 1'b0) begin
      $display("FAIL lbu_0x13: got %h err=%b, want 000000de 0", d, e);
    end else passed++;
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, d, e);
    total++;
    if (d !== 32'hFFFFDEAD || e !== 1'b0) begin
      $display("FAIL lh_0x12: got %h err=%b, want ffffdead 0", d, e);
    end else passed++;
    do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, d, e);
    total++;
    if (d !== 32'h0000BEEF || e !== 1'b0) begin
      $display("FAIL lhu_0x10: got %h err=%b, want 0000beef 0", d, e);
    end else passed++;
    do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, lat, d, e);
    total++;
    if (d !== 32'hFFFFFFEF) begin
      $display("FAIL lb_0x10: got %h, want ffffffef", d);
    end else passed++;
  endtask

  task automatic test_partial_store;
    int lat; logic [31:0] d; logic e;
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF5A, lat, d, e);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, d, e);
    total++;
    if (d !== 32'hDEAD5AEF) begin
      $display("FAIL sb_0x11: got %h, want dead5aef", d);
    end else passed++;
    do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'h11223344, lat, d, e);
    do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h7777A5B6, lat, d, e);
    do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, lat, d, e);
    total++;
    if (d !== 32'hA5B63344) begin
      $display("FAIL sh_0x16: got %h, want a5b63344", d);
    end else passed++;
  endtask

  task automatic test_errors;
    int lat; logic [31:0] d; logic e;
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, lat, d, e);
    do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, lat, d, e);
    total++;
    if (e !== 1'b1 || d !== 32'd0 || lat !== 3) begin
      $display("FAIL lw_misaligned: got err=%b rdata=%h lat=%0d, want 1 00000000 3", e, d, lat);
    end else passed++;
    do_req(1'b1, 2'b01, 1'b0, 32'h21, 32'h0000FFFF, lat, d, e);
    total++;
    if (e !== 1'b1 || d !== 32'd0) begin
      $display("FAIL sh_misaligned: got err=%b rdata=%h, want 1 00000000", e, d);
    end else passed++;
    do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, lat, d, e);
    total++;
    if (e !== 1'b1 || d !== 32'd0) begin
      $display("FAIL lw_out_of_range: got err=%b rdata=%h, want 1 00000000", e, d);
    end else passed++;
    do_req(1'b1, 2'b11, 1'b0, 32'h20, 32'h0, lat, d, e);
    total++;
    if (e !== 1'b1 || d !== 32'd0) begin
      $display("FAIL size_illegal: got err=%b rdata=%h, want 1 00000000", e, d);
    end else passed++;
    do_req(1'b1, 2'b10, 1'b0, 32'h1020, 32'h0, lat, d, e);
    total++;
    if (e !== 1'b1) begin
      $display("FAIL sw_out_of_range: got err=%b, want 1", e);
    end else passed++;
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, d, e);
    total++;
    if (d !== 32'hCAFEF00D || e !== 1'b0) begin
      $display("FAIL mem_unchanged_0x20: got %h err=%b, want cafef00d 0", d, e);
    end else passed++;
  endtask

  task automatic test_hold_and_back_to_back;
    int lat; logic [31:0] d; logic e;
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (lat !== 3) begin
      $display("FAIL hold_latency: got %0d, want 3", lat);
    end else passed++;
    // Present a competing request while the response is stalled.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h14; req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD5AEF || resp_err !== 1'b0 ||
          req_ready !== 1'b0) begin
        $display("FAIL hold_cycle%0d: got valid=%b rdata=%h err=%b ready=%b, want 1 dead5aef 0 0",
                 i, resp_valid, resp_rdata, resp_err, req_ready);
      end else passed++;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      $display("FAIL release_to_idle: got ready=%b busy=%b valid=%b, want 1 0 0",
               req_ready, busy, resp_valid);
    end else passed++;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      $display("FAIL next_accept: got busy=%b ready=%b, want 1 0", busy, req_ready);
    end else passed++;
    wait_resp(lat, d, e);
    total++;
    if (lat !== 3 || d !== 32'hA5B63344) begin
      $display("FAIL next_resp: got lat=%0d rdata=%h, want 3 a5b63344", lat, d);
    end else passed++;
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] d; logic e;
    do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h0BADF00D, lat, d, e);
    issue(1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678);
    total++;
    if (busy !== 1'b1) begin
      $display("FAIL in_wait_busy: got %b, want 1", busy);
    end else passed++;
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0) begin
      $display("FAIL async_reset: got busy=%b ready=%b valid=%b rdata=%h, want 0 1 0 00000000",
               busy, req_ready, resp_valid, resp_rdata);
    end else passed++;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, d, e);
    total++;
    if (d !== 32'h0BADF00D || e !== 1'b0) begin
      $display("FAIL abandoned_store: got %h err=%b, want 0badf00d 0", d, e);
    end else passed++;
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0; rst = 1'b0;
    test_reset;
    test_word;
    test_subword;
    test_partial_store;
    test_errors;
    test_hold_and_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
